muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV64M multiply/divide operations that the decoder flags with alu_op MUL/DIV and the alu_hi, alu_sign1, alu_sign2 and alu_32 qualifiers.
- Accepts one operation from the execute stage and runs an iterative radix-2 shift-add multiplier or a restoring divider.
- Applies sign correction and the RISC-V special cases, then returns a 64-bit result with a done pulse.
- The execute stage stalls on !ready.

Parameters:
XLEN, 64, operand/result width; only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  abort the in-flight op, no result
- start  in  1  operation valid; accepted only when ready=1
- op_div  in  1  0 = multiply (ALU_MUL), 1 = divide/remainder (ALU_DIV)
- alu_hi  in  1  mul: high 64 bits; div: remainder
- alu_sign1  in  1  src1 is signed
- alu_sign2  in  1  src2 is signed
- alu_32  in  1  *W form: 32-bit operands, sign-extended 32-bit result
- src1  in  64  multiplicand / dividend
- src2  in  64  multiplier / divisor
- ready  out  1  state==IDLE; combinational from state
- done  out  1  one-cycle pulse, result valid
- result  out  64  registered; held until the next done

Behaviour:
- Reset values: state=IDLE, ready=1, done=0, result=0, all internal registers 0.

- Capture: on start&&ready&&!flush, latch the qualifiers and the operands.
  - alu_32=1: src1 is taken as {sign1?sext:zext}(src1[31:0]); src2 likewise with sign2.
  - Operand sign: neg1 = sign1 & msb1; neg2 = sign2 & msb2 (msb = bit 63, or bit 31 when alu_32).
  - Magnitudes are the absolute values of the operands. The counter is loaded with N = alu_32 ? 32 : 64.

- States:
  - IDLE
    - Fast path (divide only), IDLE->DONE:
      - Divide by zero, divisor==0 (32-bit compare when alu_32): quotient = all ones, remainder = dividend.
      - Signed overflow, sign1&sign2 with dividend==MIN and divisor==-1 at the active width: quotient = dividend, remainder = 0.
    - Otherwise IDLE->CALC.
  - CALC: one iteration per cycle; counter decrements; CALC->FIX when the counter reaches 0 (exactly N CALC cycles).
    - Mul: 128-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1.
    - Div: shift the remainder left by 1 and bring in the next dividend bit. Trial-subtract the divisor; if the difference is non-negative, keep it and set the quotient bit to 1.
  - FIX: one cycle; applies sign correction, selects the result and registers it.
    - Product is negated if neg1^neg2.
    - Quotient is negated if neg1^neg2; remainder is negated if neg1.
    - Select: mul lo = p[63:0]; mul hi = p[127:64]; div = quotient; alu_hi = remainder.
    - alu_32: result = sext(selected[31:0]); alu_hi is ignored for mul (no MULHW).
  - DONE: done=1 for exactly this cycle, then DONE->IDLE.

- Latency (start accepted in cycle 0):
  - Normal path: done in cycle N+2, i.e. 66 (64-bit) or 34 (32-bit); next start accepted in cycle N+3.
  - Fast path: done in cycle 1.

- Handshake:
  - start while ready=0 is ignored; no queueing.
  - Inputs are don't-care outside the accept cycle.

- Flush:
  - Any state goes to IDLE on the next cycle; done is suppressed and result keeps its old value.
  - start and flush in the same cycle: flush wins and the op is not accepted.
  - flush during DONE: done has already pulsed that cycle; no effect beyond the return to IDLE.

- rst mid-operation: same as flush, and additionally clears result to 0.

Test Plan:
1. MUL signed, src1=7, src2=0xFFFF_FFFF_FFFF_FFFD, alu_hi=0 -> result=0xFFFF_FFFF_FFFF_FFEB; done exactly in cycle 66; ready=0 in cycles 1-66.
2. MULHU, src1=src2=0xFFFF_FFFF_FFFF_FFFF, alu_hi=1 -> result=0xFFFF_FFFF_FFFF_FFFE.
   - Same operands as MULHSU (sign1=1, sign2=0) -> 0xFFFF_FFFF_FFFF_FFFF.
   - MULW, src1=0x0000_0000_8000_0000, src2=2 -> 0.
3. Divide by zero:
   - DIVU 100/0 -> 0xFFFF_FFFF_FFFF_FFFF, done in cycle 1.
   - REMU 100/0 -> 100.
   - DIVW 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
4. Signed overflow:
   - DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; REM of the same -> 0; done in cycle 1.
   - DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
5. DIVW / REMW / DIVUW:
   - DIVW src1[31:0]=0xFFFF_FFF9 (-7), src2=2 -> 0xFFFF_FFFF_FFFF_FFFD, done in cycle 34.
   - REMW of the same -> 0xFFFF_FFFF_FFFF_FFFF.
   - DIVUW 0xFFFF_FFFF/1 -> 0xFFFF_FFFF_FFFF_FFFF.
6. Control:
   - start a DIV, pulse flush in cycle 10 -> no done ever, ready=1 in cycle 11, result unchanged.
   - start asserted in cycles 2-5 of a busy op -> ignored.
   - start+flush in the same cycle -> not accepted.
   - rst in cycle 20 of a MUL -> ready=1, done=0, result=0 in the next cycle.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer: radix-2 shift-add multiply or restoring divide,
// with RISC-V divide-by-zero/overflow fast path and sign fix-up before the done pulse.
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic            op_div,
  input  logic            alu_hi,
  input  logic            alu_sign1,
  input  logic            alu_sign2,
  input  logic            alu_32,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [127:0] a_q, a_d, acc_q, acc_d;
  logic [63:0]  b_q, b_d, result_q, result_d;
  logic         div_q, div_d, hi_q, hi_d, w_q, w_d;
  logic         neg1_q, neg1_d, neg2_q, neg2_d;

  logic [63:0]  s1, s2, mag1, mag2, fast_sel, quo, rem, sel;
  logic         neg1, neg2, dz, ovf, ge;
  logic [64:0]  rem_sh;
  logic [127:0] prod;

  // Operand conditioning and the divide special cases, evaluated on the accept cycle
  always_comb begin
    s1 = alu_32 ? (alu_sign1 ? {{32{src1[31]}}, src1[31:0]} : {32'd0, src1[31:0]}) : src1;
    s2 = alu_32 ? (alu_sign2 ? {{32{src2[31]}}, src2[31:0]} : {32'd0, src2[31:0]}) : src2;
    neg1 = alu_sign1 & s1[63];
    neg2 = alu_sign2 & s2[63];
    mag1 = neg1 ? -s1 : s1;
    mag2 = neg2 ? -s2 : s2;
    dz   = alu_32 ? (s2[31:0] == 32'd0) : (s2 == 64'd0);
    ovf  = alu_sign1 & alu_sign2 &
           (alu_32 ? (s1[31:0] == 32'h8000_0000 && s2[31:0] == 32'hFFFF_FFFF)
                   : (s1 == 64'h8000_0000_0000_0000 && s2 == 64'hFFFF_FFFF_FFFF_FFFF));
    if (dz) fast_sel = alu_hi ? s1 : 64'hFFFF_FFFF_FFFF_FFFF;
    else    fast_sel = alu_hi ? 64'd0 : s1;
  end

  // Divide step datapath and final sign correction / result select
  always_comb begin
    rem_sh = {acc_q[63:0], b_q[63]};
    ge     = rem_sh >= {1'b0, a_q[63:0]};
    prod   = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
    quo    = (neg1_q ^ neg2_q) ? -b_q : b_q;
    rem    = neg1_q ? -acc_q[63:0] : acc_q[63:0];
    if (div_q) sel = hi_q ? rem : quo;
    else       sel = (hi_q && !w_q) ? prod[127:64] : prod[63:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    div_d    = div_q;
    hi_d     = hi_q;
    w_d      = w_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          div_d  = op_div;
          hi_d   = alu_hi;
          w_d    = alu_32;
          neg1_d = neg1;
          neg2_d = neg2;
          cnt_d  = alu_32 ? 7'd32 : 7'd64;
          acc_d  = 128'd0;
          if (op_div) begin
            a_d = {64'd0, mag2};
            // 32-bit dividends are pre-aligned so the first bit shifted out is bit 31
            b_d = alu_32 ? {mag1[31:0], 32'd0} : mag1;
          end else begin
            a_d = {64'd0, mag1};
            b_d = mag2;
          end
          if (op_div && (dz || ovf)) begin
            result_d = alu_32 ? {{32{fast_sel[31]}}, fast_sel[31:0]} : fast_sel;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - 7'd1;
        if (div_q) begin
          b_d   = {b_q[62:0], ge};
          acc_d = {64'd0, ge ? (rem_sh[63:0] - a_q[63:0]) : rem_sh[63:0]};
        end else begin
          acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end
        if (cnt_q == 7'd1) state_d = FIX;
      end
      FIX: begin
        result_d = w_q ? {{32{sel[31]}}, sel[31:0]} : sel;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      a_q      <= 128'd0;
      acc_q    <= 128'd0;
      b_q      <= 64'd0;
      result_q <= 64'd0;
      div_q    <= 1'b0;
      hi_q     <= 1'b0;
      w_q      <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      div_q    <= div_d;
      hi_q     <= hi_d;
      w_q      <= w_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed RV64M results, latencies, flush/reset/handshake behaviour.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, flush, start, op_div, alu_hi, alu_sign1, alu_sign2, alu_32;
  logic [63:0] src1, src2;
  logic        ready, done;
  logic [63:0] result;

  int          total = 0;
  int          bad = 0;
  logic [63:0] last_res = 64'd0;

  muldiv_seq #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op_div(op_div),
    .alu_hi(alu_hi), .alu_sign1(alu_sign1), .alu_sign2(alu_sign2), .alu_32(alu_32),
    .src1(src1), .src2(src2), .ready(ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge; cycle 0 is the accept cycle.
  // abort_at>0 pulses flush (or rst when abort_rst) in that cycle instead of waiting for done.
  task automatic applyStimulus(input string tag, input bit div, input bit hi, input bit sg1,
                               input bit sg2, input bit w, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] exp_res,
                               input int exp_lat, input int abort_at, input bit abort_rst,
                               input bit junk);
    int          lat, dones, busy_hits, limit;
    logic [63:0] done_res, exp_after;
    logic        rdy_after;
    lat = 0; dones = 0; busy_hits = 0; done_res = 64'd0; rdy_after = 1'b0;
    limit = (abort_at > 0) ? 90 : exp_lat + 4;
    op_div = div; alu_hi = hi; alu_sign1 = sg1; alu_sign2 = sg2; alu_32 = w;
    src1 = a; src2 = b; start = 1'b1;
    @(negedge clk);
    src1 = 64'hDEAD_BEEF_0BAD_F00D; src2 = 64'd3; op_div = ~div; alu_hi = ~hi; alu_32 = ~w;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (done) begin
        dones++;
        if (dones == 1) begin
          lat = cyc;
          done_res = result;
        end
      end
      if (abort_at == 0 && cyc <= exp_lat && ready) busy_hits++;
      if (abort_at > 0 && cyc == abort_at + 1) rdy_after = ready;
      if (abort_at == 0 && cyc == exp_lat + 1) rdy_after = ready;
      start = junk && cyc >= 2 && cyc <= 5;
      flush = (cyc == abort_at) && !abort_rst;
      rst   = (cyc == abort_at) && abort_rst;
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0; rst = 1'b0;
    if (abort_at > 0) begin
      exp_after = abort_rst ? 64'd0 : last_res;
      checkOutput({tag, "_nodone"}, 64'(dones), 64'd0);
      checkOutput({tag, "_ready"}, {63'd0, rdy_after}, 64'd1);
      checkOutput({tag, "_result"}, result, exp_after);
      last_res = exp_after;
    end else begin
      checkOutput({tag, "_dones"}, 64'(dones), 64'd1);
      checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      checkOutput({tag, "_res"}, done_res, exp_res);
      checkOutput({tag, "_held"}, result, exp_res);
      checkOutput({tag, "_busy"}, 64'(busy_hits), 64'd0);
      checkOutput({tag, "_ready"}, {63'd0, rdy_after}, 64'd1);
      last_res = exp_res;
    end
  endtask

  initial begin
    int dones;
    rst = 1'b1; flush = 1'b0; start = 1'b0; op_div = 1'b0; alu_hi = 1'b0;
    alu_sign1 = 1'b0; alu_sign2 = 1'b0; alu_32 = 1'b0; src1 = 64'd0; src2 = 64'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {63'd0, ready}, 64'd1);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Multiplies
    applyStimulus("mul", 0, 0, 1, 1, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                  64'hFFFF_FFFF_FFFF_FFEB, 66, 0, 0, 0);
    applyStimulus("mulhu", 0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 0, 0);
    applyStimulus("mulhsu", 0, 1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFF, 66, 0, 0, 0);
    applyStimulus("mulh_pos", 0, 1, 1, 1, 0, 64'h4000_0000_0000_0000, 64'd4,
                  64'd1, 66, 0, 0, 0);
    applyStimulus("mulw", 0, 0, 1, 1, 1, 64'h0000_0000_8000_0000, 64'd2,
                  64'd0, 34, 0, 0, 0);
    applyStimulus("mulw_neg", 0, 0, 1, 1, 1, 64'h1234_5678_FFFF_FFFD, 64'd5,
                  64'hFFFF_FFFF_FFFF_FFF1, 34, 0, 0, 0);

    // Divide by zero and signed overflow fast path
    applyStimulus("divu_z", 1, 0, 0, 0, 0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
    applyStimulus("remu_z", 1, 1, 0, 0, 0, 64'd100, 64'd0, 64'd100, 1, 0, 0, 0);
    applyStimulus("divw_z", 1, 0, 1, 1, 1, 64'd5, 64'hABCD_0000_0000_0000,
                  64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
    applyStimulus("div_ovf", 1, 0, 1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 1, 0, 0, 0);
    applyStimulus("rem_ovf", 1, 1, 1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'd0, 1, 0, 0, 0);
    applyStimulus("divw_ovf", 1, 0, 1, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                  64'hFFFF_FFFF_8000_0000, 1, 0, 0, 0);

    // Iterative divides
    applyStimulus("divu", 1, 0, 0, 0, 0, 64'd100, 64'd7, 64'd14, 66, 0, 0, 0);
    applyStimulus("remu", 1, 1, 0, 0, 0, 64'd100, 64'd7, 64'd2, 66, 0, 0, 0);
    applyStimulus("div_neg", 1, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                  64'hFFFF_FFFF_FFFF_FFF2, 66, 0, 0, 0);
    applyStimulus("rem_neg", 1, 1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                  64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 0, 0);
    applyStimulus("divw", 1, 0, 1, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFD, 34, 0, 0, 0);
    applyStimulus("remw", 1, 1, 1, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFF, 34, 0, 0, 0);
    applyStimulus("divuw", 1, 0, 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1,
                  64'hFFFF_FFFF_FFFF_FFFF, 34, 0, 0, 0);

    // Control: busy start ignored, flush, start+flush, reset mid-op
    applyStimulus("junk", 1, 0, 0, 0, 0, 64'd1000, 64'd10, 64'd100, 66, 0, 0, 1);
    applyStimulus("flush", 1, 0, 1, 1, 0, 64'd12345, 64'd11, 64'd0, 0, 10, 0, 0);

    op_div = 1'b1; alu_hi = 1'b0; alu_sign1 = 1'b0; alu_sign2 = 1'b0; alu_32 = 1'b0;
    src1 = 64'd50; src2 = 64'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("stflush_ready", {63'd0, ready}, 64'd1);
    dones = 0;
    for (int i = 0; i < 70; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checkOutput("stflush_nodone", 64'(dones), 64'd0);
    checkOutput("stflush_result", result, last_res);

    applyStimulus("rstmid", 0, 0, 0, 0, 0, 64'd9, 64'd9, 64'd0, 0, 20, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
